// File: rtl/mdu.sv
// Iterative multiply/divide unit with private HI/LO registers, MTHI/MTLO writes and busy/done handshake.
// Define MDU_FAST_MUL_EN to compute MULT/MULTU in a single cycle; division always stays iterative.
module mdu #(
    parameter int MUL_ITER = 32,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [1:0]  opReg;
    logic [31:0] operand;
    logic [63:0] acc;
    logic        negRes;
    logic        negRem;
    logic        divZero;
    logic [5:0]  counter;
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic        doneReg;

    // Operand conditioning at launch: signed ops work on magnitudes and remember the signs.
    logic        isSigned;
    logic        signA;
    logic        signB;
    logic [31:0] magA;
    logic [31:0] magB;

    assign isSigned = ~op[0];
    assign signA    = isSigned & srcA[31];
    assign signB    = isSigned & srcB[31];
    assign magA     = signA ? (32'd0 - srcA) : srcA;
    assign magB     = signB ? (32'd0 - srcB) : srcB;

    // One shift-add multiply step: acc = {partial product, remaining multiplier bits}.
    logic [32:0] mulSum;
    logic [63:0] mulNext;
    assign mulSum  = {1'b0, acc[63:32]} + {1'b0, operand};
    assign mulNext = acc[0] ? {mulSum, acc[31:1]} : {1'b0, acc[63:1]};

    // One restoring divide step: acc = {remainder, dividend bits shifting into quotient}.
    logic [32:0] divShift;
    logic [32:0] divDiff;
    logic [63:0] divNext;
    assign divShift = {acc[63:32], acc[31]};
    assign divDiff  = divShift - {1'b0, operand};
    assign divNext  = divDiff[32] ? {divShift[31:0], acc[30:0], 1'b0}
                                  : {divDiff[31:0], acc[30:0], 1'b1};

    logic lastIter;
    assign lastIter = opReg[1] ? (counter == 6'(DIV_ITER - 1))
                               : (counter == 6'(MUL_ITER - 1));

    logic launchFast;
`ifdef MDU_FAST_MUL_EN
    assign launchFast = ~op[1];
`else
    assign launchFast = 1'b0;
`endif

    // Sign correction applied when committing.
    logic [63:0] prodFixed;
    logic [31:0] quoFixed;
    logic [31:0] remFixed;
    assign prodFixed = negRes ? (64'd0 - acc) : acc;
    assign quoFixed  = divZero ? 32'hFFFF_FFFF
                               : (negRes ? (32'd0 - acc[31:0]) : acc[31:0]);
    assign remFixed  = negRem ? (32'd0 - acc[63:32]) : acc[63:32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = launchFast ? FIX : RUN;
                end
            end
            RUN: begin
                if (lastIter) begin
                    stateNext = FIX;
                end
            end
            FIX: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opReg   <= 2'd0;
            operand <= 32'd0;
            acc     <= 64'd0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            counter <= 6'd0;
            hiReg   <= 32'd0;
            loReg   <= 32'd0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opReg   <= op;
                        negRes  <= signA ^ signB;
                        negRem  <= signA;
                        divZero <= (srcB == 32'd0);
                        counter <= 6'd0;
                        if (op[1]) begin
                            operand <= magB;
                            acc     <= {32'd0, magA};
                        end else if (launchFast) begin
                            operand <= magA;
                            acc     <= {32'd0, magA} * {32'd0, magB};
                        end else begin
                            operand <= magA;
                            acc     <= {32'd0, magB};
                        end
                    end else begin
                        if (hi_we) begin
                            hiReg <= wdata;
                        end
                        if (lo_we) begin
                            loReg <= wdata;
                        end
                    end
                end
                RUN: begin
                    acc     <= opReg[1] ? divNext : mulNext;
                    counter <= counter + 6'd1;
                end
                FIX: begin
                    if (opReg[1]) begin
                        hiReg <= remFixed;
                        loReg <= quoFixed;
                    end else begin
                        hiReg <= prodFixed[63:32];
                        loReg <= prodFixed[31:0];
                    end
                    doneReg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = doneReg;
    assign hi   = hiReg;
    assign lo   = loReg;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vector table, hand-written corner sequences and
// randomized operations compared against an arithmetic reference model.
module tb_mdu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] curHi = 32'd0;
    logic [31:0] curLo = 32'd0;

    mdu dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic with the architectural special cases.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l);
        longint      sp;
        logic [63:0] up;
        int          q;
        int          r;
        case (o)
            2'b00: begin
                sp = longint'(int'(a)) * longint'(int'(b));
                up = 64'(sp);
                h = up[63:32];
                l = up[31:0];
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                h = up[63:32];
                l = up[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    h = 32'd0;
                    l = 32'h8000_0000;
                end else begin
                    q = int'(a) / int'(b);
                    r = int'(a) % int'(b);
                    h = 32'(r);
                    l = 32'(q);
                end
            end
            default: begin
                if (b == 32'd0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else begin
                    h = a % b;
                    l = a / b;
                end
            end
        endcase
    endtask

    function automatic int expLatency(input logic [1:0] o);
`ifdef MDU_FAST_MUL_EN
        return o[1] ? 33 : 1;
`else
        return 33;
`endif
    endfunction

    // Counts edges after T0 until done is seen; returns 100 on timeout.
    task automatic waitDone(input bit checkHold, output int cycles);
        bit got;
        cycles = 0;
        got = 1'b0;
        while (cycles < 100 && !got) begin
            if (checkHold && cycles == 10) begin
                check("hold_hi_run", {32'd0, hi}, {32'd0, curHi});
                check("hold_lo_run", {32'd0, lo}, {32'd0, curLo});
            end
            @(posedge clk);
            #1;
            cycles++;
            if (done) got = 1'b1;
        end
    endtask

    task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int cycles;
        int lat;
        lat = expLatency(o);
        @(negedge clk);
        start = 1'b1;
        op = o;
        srcA = a;
        srcB = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, "_busy"}, {63'd0, busy}, 64'd1);
        waitDone(lat > 12, cycles);
        check({name, "_latency"}, 64'(cycles), 64'(lat));
        check({name, "_hi"}, {32'd0, hi}, {32'd0, eh});
        check({name, "_lo"}, {32'd0, lo}, {32'd0, el});
        check({name, "_busy_end"}, {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        check({name, "_done_single"}, {63'd0, done}, 64'd0);
        curHi = eh;
        curLo = el;
        $display("op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h cycles=%0d", o, a, b, hi, lo, cycles);
    endtask

    vec_t vecs[8];

    initial begin
        int          cycles;
        int          doneCount;
        logic [31:0] mh;
        logic [31:0] ml;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b11, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E};
        vecs[4] = '{2'b11, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF};
        vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6] = '{2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7] = '{2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F};

        rst = 1'b1;
        start = 1'b0;
        op = 2'b00;
        srcA = 32'd0;
        srcB = 32'd0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].expHi, vecs[i].expLo);
        end

        // MTLO in IDLE
        @(negedge clk);
        lo_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        check("mtlo_lo", {32'd0, lo}, 64'hDEAD_BEEF);
        check("mtlo_hi", {32'd0, hi}, {32'd0, curHi});
        check("mtlo_done", {63'd0, done}, 64'd0);
        curLo = 32'hDEAD_BEEF;
        $display("mtlo wdata=0x%08h -> lo=0x%08h", wdata, lo);

        // MTHI + MTLO together
        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hA5A5_0001;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mtboth_hi", {32'd0, hi}, 64'hA5A5_0001);
        check("mtboth_lo", {32'd0, lo}, 64'hA5A5_0001);
        curHi = 32'hA5A5_0001;
        curLo = 32'hA5A5_0001;
        $display("mthi+mtlo wdata=0x%08h -> hi=0x%08h lo=0x%08h", wdata, hi, lo);

        // start and hi_we together: start wins
        @(negedge clk);
        start = 1'b1;
        op = 2'b11;
        srcA = 32'd12;
        srcB = 32'd5;
        hi_we = 1'b1;
        wdata = 32'h5555_5555;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        check("startwins_busy", {63'd0, busy}, 64'd1);
        check("startwins_hi_now", {32'd0, hi}, {32'd0, curHi});
        waitDone(1'b0, cycles);
        check("startwins_latency", 64'(cycles), 64'd33);
        check("startwins_hi", {32'd0, hi}, 64'd2);
        check("startwins_lo", {32'd0, lo}, 64'd2);
        curHi = 32'd2;
        curLo = 32'd2;
        $display("start+hi_we DIVU 12/5 -> hi=0x%08h lo=0x%08h", hi, lo);

        // Second start and MTHI while busy are ignored
        @(negedge clk);
        start = 1'b1;
`ifdef MDU_FAST_MUL_EN
        op = 2'b11;
        srcA = 32'd12;
        srcB = 32'd1;
`else
        op = 2'b01;
        srcA = 32'd3;
        srcB = 32'd4;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        doneCount = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (k == 5);
            op = 2'b10;
            srcA = 32'h100;
            srcB = 32'd3;
            hi_we = (k == 10);
            wdata = 32'h1234;
            @(posedge clk);
            #1;
            if (done) doneCount++;
        end
        start = 1'b0;
        hi_we = 1'b0;
        check("busyign_done_count", 64'(doneCount), 64'd1);
        check("busyign_hi", {32'd0, hi}, 64'd0);
        check("busyign_lo", {32'd0, lo}, 64'hC);
        check("busyign_busy", {63'd0, busy}, 64'd0);
        curHi = 32'd0;
        curLo = 32'hC;
        $display("busy-ignore sequence -> hi=0x%08h lo=0x%08h dones=%0d", hi, lo, doneCount);

        // Reset in mid-divide
        runOp("prefill", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0);
        @(negedge clk);
        start = 1'b1;
        op = 2'b10;
        srcA = 32'hFFFF_FF00;
        srcB = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_busy", {63'd0, busy}, 64'd0);
        check("rstmid_done", {63'd0, done}, 64'd0);
        check("rstmid_hi", {32'd0, hi}, 64'd0);
        check("rstmid_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        doneCount = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) doneCount++;
        end
        check("rstmid_no_done", 64'(doneCount), 64'd0);
        check("rstmid_lo_after", {32'd0, lo}, 64'd0);
        curHi = 32'd0;
        curLo = 32'd0;
        $display("reset mid-DIV -> busy=%0d hi=0x%08h lo=0x%08h dones=%0d", busy, hi, lo, doneCount);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            model(ro, ra, rb, mh, ml);
            runOp($sformatf("rnd%0d", i), ro, ra, rb, mh, ml);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
